// File: rtl/rvv_xrf_wb_arbiter.sv
// rvv_xrf_wb_arbiter: merges up to N_SRC per-lane scalar write-back requests
// into one in-order FIFO, drained one entry per cycle onto the async_rd port.
module rvv_xrf_wb_arbiter #(
  parameter int unsigned N_SRC  = 4,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_SRC-1:0]           src_valid,
  input  logic [N_SRC*ADDR_W-1:0]    src_addr,
  input  logic [N_SRC*DATA_W-1:0]    src_data,
  output logic [N_SRC-1:0]           src_ready,
  output logic                       async_rd_valid,
  output logic [ADDR_W-1:0]          async_rd_addr,
  output logic [DATA_W-1:0]          async_rd_data,
  input  logic                       async_rd_ready,
  output logic [$clog2(DEPTH+1)-1:0] fill_level
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  wp_q, wp_d;
  logic [PTR_W-1:0]  rp_q, rp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q [DEPTH];
  logic [ADDR_W-1:0] mem_addr_d [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [DATA_W-1:0] mem_data_d [DEPTH];
  logic [CNT_W-1:0]  enq_cnt;
  logic [PTR_W-1:0]  wr_idx;
  logic              deq;

  // Lane i is ready when at least i+1 slots are free before any dequeue.
  always_comb begin
    src_ready = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      src_ready[i] = !rst && ((DEPTH - 32'(cnt_q)) > 32'(i));
    end
  end

  // Compact accepted lanes, lowest index first, into consecutive slots from wp.
  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    enq_cnt    = '0;
    wr_idx     = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (src_valid[i] && src_ready[i]) begin
        wr_idx             = PTR_W'((32'(wp_q) + 32'(enq_cnt)) % DEPTH);
        mem_addr_d[wr_idx] = src_addr[i*ADDR_W +: ADDR_W];
        mem_data_d[wr_idx] = src_data[i*DATA_W +: DATA_W];
        enq_cnt            = CNT_W'(32'(enq_cnt) + 32'd1);
      end
    end
  end

  // Head entry presentation; zeros when empty.
  always_comb begin
    async_rd_valid = (cnt_q != '0);
    async_rd_addr  = async_rd_valid ? mem_addr_q[rp_q] : '0;
    async_rd_data  = async_rd_valid ? mem_data_q[rp_q] : '0;
    fill_level     = cnt_q;
  end

  // Pointer and occupancy update for simultaneous enqueue/dequeue.
  always_comb begin
    deq   = async_rd_valid && async_rd_ready;
    wp_d  = PTR_W'((32'(wp_q) + 32'(enq_cnt)) % DEPTH);
    rp_d  = deq ? PTR_W'((32'(rp_q) + 32'd1) % DEPTH) : rp_q;
    cnt_d = CNT_W'(32'(cnt_q) + 32'(enq_cnt) - 32'(deq));
  end

  // Control state with synchronous reset; buffered entries are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are don't-care outside the occupied window.
  always_ff @(posedge clk) begin
    mem_addr_q <= mem_addr_d;
    mem_data_q <= mem_data_d;
  end

endmodule

// File: tb/tb_rvv_xrf_wb_arbiter.sv
// Bench for rvv_xrf_wb_arbiter: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_rvv_xrf_wb_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned D  = 8;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic              clk;
  logic              rst;
  logic [N-1:0]      src_valid;
  logic [N*AW-1:0]   src_addr;
  logic [N*DW-1:0]   src_data;
  logic [N-1:0]      src_ready;
  logic              async_rd_valid;
  logic [AW-1:0]     async_rd_addr;
  logic [DW-1:0]     async_rd_data;
  logic              async_rd_ready;
  logic [3:0]        fill_level;

  rvv_xrf_wb_arbiter #(.N_SRC(N), .DEPTH(D), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .src_valid     (src_valid),
    .src_addr      (src_addr),
    .src_data      (src_data),
    .src_ready     (src_ready),
    .async_rd_valid(async_rd_valid),
    .async_rd_addr (async_rd_addr),
    .async_rd_data (async_rd_data),
    .async_rd_ready(async_rd_ready),
    .fill_level    (fill_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of {addr, data}.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t         q[$];
  logic [N-1:0] acc = '0;
  bit           chk_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      acc    = '0;
      chk_en = 1;
    end else begin
      int   free;
      ent_t e;
      free = int'(D) - q.size();
      acc  = '0;
      if (q.size() != 0 && async_rd_ready) void'(q.pop_front());
      for (int i = 0; i < int'(N); i++) begin
        if (src_valid[i] && free > i) begin
          acc[i] = 1'b1;
          e.a = src_addr[i*AW +: AW];
          e.d = src_data[i*DW +: DW];
          q.push_back(e);
        end
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [N-1:0]  er;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      for (int i = 0; i < int'(N); i++) er[i] = !rst && ((int'(D) - q.size()) > i);
      ea = (q.size() != 0) ? q[0].a : '0;
      ed = (q.size() != 0) ? q[0].d : '0;
      chk("m_ready", 64'(src_ready), 64'(er));
      chk("m_valid", 64'(async_rd_valid), 64'(q.size() != 0));
      chk("m_addr", 64'(async_rd_addr), 64'(ea));
      chk("m_data", 64'(async_rd_data), 64'(ed));
      chk("m_fill", 64'(fill_level), 64'(q.size()));
      chk("m_fill_le_depth", 64'(fill_level <= 4'(D)), 64'd1);
    end
  end

  task automatic set_lane(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    src_addr[i*AW +: AW] = a;
    src_data[i*DW +: DW] = d;
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  logic [DW-1:0] seq_data;

  initial begin
    rst = 1'b1;
    src_valid = '0;
    src_addr = '0;
    src_data = '0;
    async_rd_ready = 1'b0;
    seq_data = 32'h1000_0000;

    // Reset state
    nedge(); nedge();
    chk("rst_valid", 64'(async_rd_valid), 64'd0);
    chk("rst_fill", 64'(fill_level), 64'd0);
    chk("rst_addr", 64'(async_rd_addr), 64'd0);
    chk("rst_data", 64'(async_rd_data), 64'd0);
    chk("rst_ready", 64'(src_ready), 64'h0);
    rst = 1'b0;
    nedge();
    chk("post_rst_ready", 64'(src_ready), 64'hF);

    // Single lane, latency 1
    src_valid = 4'b0001; set_lane(0, 5'd5, 32'hDEAD_BEEF); async_rd_ready = 1'b1;
    nedge();
    src_valid = '0;
    chk("t1_valid", 64'(async_rd_valid), 64'd1);
    chk("t1_addr", 64'(async_rd_addr), 64'd5);
    chk("t1_data", 64'(async_rd_data), 64'hDEAD_BEEF);
    chk("t1_fill1", 64'(fill_level), 64'd1);
    nedge();
    chk("t1_fill0", 64'(fill_level), 64'd0);
    chk("t1_empty", 64'(async_rd_valid), 64'd0);

    // Sparse lanes {1,3}, same register: order kept
    src_valid = 4'b1010; set_lane(1, 5'd7, 32'd1); set_lane(3, 5'd7, 32'd2);
    nedge();
    src_valid = '0;
    chk("t2_first", 64'(async_rd_data), 64'd1);
    chk("t2_fill2", 64'(fill_level), 64'd2);
    nedge();
    chk("t2_second", 64'(async_rd_data), 64'd2);
    chk("t2_addr", 64'(async_rd_addr), 64'd7);
    nedge();
    chk("t2_fill0", 64'(fill_level), 64'd0);

    // Fill to full with backpressure (wraps the pointers)
    async_rd_ready = 1'b0; src_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_lane(i, 5'(i + 1), 32'h100 + 32'(i));
    nedge();
    for (int i = 0; i < 4; i++) set_lane(i, 5'(i + 10), 32'h104 + 32'(i));
    nedge();
    chk("t3_full_fill", 64'(fill_level), 64'd8);
    chk("t3_full_ready", 64'(src_ready), 64'h0);
    chk("t3_head", 64'(async_rd_data), 64'h100);
    src_valid = '0; async_rd_ready = 1'b1;
    nedge();
    chk("t3_fill7", 64'(fill_level), 64'd7);
    chk("t3_ready1", 64'(src_ready), 64'h1);
    chk("t3_head2", 64'(async_rd_data), 64'h101);
    nedge();
    chk("t4_fill6", 64'(fill_level), 64'd6);
    chk("t4_ready", 64'(src_ready), 64'h3);

    // Partial acceptance: lanes 2,3 must hold until space opens
    async_rd_ready = 1'b0; src_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_lane(i, 5'(i + 20), 32'h200 + 32'(i));
    nedge();
    chk("t4_fill8", 64'(fill_level), 64'd8);
    src_valid = 4'b1100; async_rd_ready = 1'b1;
    nedge();
    chk("t4_fill7", 64'(fill_level), 64'd7);
    chk("t4_ready7", 64'(src_ready), 64'h1);
    nedge();
    chk("t4_fill6b", 64'(fill_level), 64'd6);
    nedge();
    chk("t4_fill5", 64'(fill_level), 64'd5);
    chk("t4_ready5", 64'(src_ready), 64'h7);
    nedge();
    src_valid = 4'b1000;
    chk("t4_fill5b", 64'(fill_level), 64'd5);
    nedge();
    chk("t4_fill4", 64'(fill_level), 64'd4);
    chk("t4_ready4", 64'(src_ready), 64'hF);
    nedge();
    src_valid = '0;
    chk("t4_fill4b", 64'(fill_level), 64'd4);
    repeat (5) nedge();
    chk("t4_drained", 64'(fill_level), 64'd0);

    // Reset mid-operation at cnt=5
    async_rd_ready = 1'b0; src_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_lane(i, 5'(i + 3), 32'h300 + 32'(i));
    nedge();
    src_valid = 4'b0001; set_lane(0, 5'd9, 32'h304);
    nedge();
    chk("t5_fill5", 64'(fill_level), 64'd5);
    rst = 1'b1; src_valid = 4'b1111; async_rd_ready = 1'b1;
    nedge();
    chk("t5_rst_valid", 64'(async_rd_valid), 64'd0);
    chk("t5_rst_fill", 64'(fill_level), 64'd0);
    rst = 1'b0; src_valid = '0;
    nedge();
    chk("t5_after_fill", 64'(fill_level), 64'd0);
    chk("t5_after_ready", 64'(src_ready), 64'hF);

    // Random stress; a lane not accepted holds its request
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!src_valid[i] || acc[i]) begin
          src_valid[i] = ($urandom_range(0, 99) < 45);
          set_lane(i, 5'($urandom_range(0, 31)), seq_data);
          seq_data = seq_data + 32'd1;
        end
      end
      async_rd_ready = ($urandom_range(0, 99) < 60);
      nedge();
    end
    src_valid = '0; async_rd_ready = 1'b1;
    repeat (12) nedge();
    chk("final_empty", 64'(fill_level), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
